// File: rtl/alu_pkg.sv
// Shared definitions for the sequential nibble-serial ALU: FSM states, op encodings, slice width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aluState;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_addsub.sv
// One 4-bit add/subtract slice; also exposes the carry into bit 3 for overflow detection.
module nibble_addsub
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] bEff;
    logic [NIBBLE_W:0]   fullSum;
    logic [NIBBLE_W-1:0] lowSum;

    assign bEff    = b ^ {NIBBLE_W{sub}};
    assign fullSum = {1'b0, a} + {1'b0, bEff} + {{NIBBLE_W{1'b0}}, cin};
    // Carry into the top bit comes from summing only the lower three bits.
    assign lowSum  = {1'b0, a[2:0]} + {1'b0, bEff[2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};

    assign s    = fullSum[NIBBLE_W-1:0];
    assign cout = fullSum[NIBBLE_W];
    assign c3   = lowSum[NIBBLE_W-1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial add/subtract unit: one 4-bit slice per RUN cycle through a single shared adder.
// Optional signed overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      op,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    output logic                      busy,
    output logic                      done,
    output logic [4*NIBBLES-1:0]      result,
    output logic                      cout
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    aluState state;
    aluState nextState;

    logic [W-1:0]        aReg;
    logic [W-1:0]        bReg;
    logic                opReg;
    logic                carry;
    logic [IDXW-1:0]     idx;
    logic [NIBBLE_W-1:0] sliceA;
    logic [NIBBLE_W-1:0] sliceB;
    logic [NIBBLE_W-1:0] sliceS;
    logic                sliceCout;
    logic                sliceC3;

    assign sliceA = aReg[idx*NIBBLE_W +: NIBBLE_W];
    assign sliceB = bReg[idx*NIBBLE_W +: NIBBLE_W];

    nibble_addsub uSlice (
        .a    (sliceA),
        .b    (sliceB),
        .sub  (opReg),
        .cin  (carry),
        .s    (sliceS),
        .cout (sliceCout),
        .c3   (sliceC3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Flags are captured on the final slice so they are already valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg   <= '0;
            bReg   <= '0;
            opReg  <= OP_ADD;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg   <= a;
                        bReg   <= b;
                        opReg  <= op;
                        carry  <= op;
                        idx    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                        ovf    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result[idx*NIBBLE_W +: NIBBLE_W] <= sliceS;
                    carry <= sliceCout;
                    if (idx == LAST_IDX) begin
                        idx  <= '0;
                        cout <= sliceCout ^ opReg;
`ifdef ALU_SEQ_OVF_EN
                        ovf  <= sliceCout ^ sliceC3;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl (NIBBLES=4); checks ovf as well when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
    } expT;

    expT sbQueue[$];
    int  passCount  = 0;
    int  failCount  = 0;
    int  checkCount = 0;

    alu_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef ALU_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic expT model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        expT        e;
        logic [W:0] full;
        if (!o) begin
            full     = {1'b0, x} + {1'b0, y};
            e.result = full[W-1:0];
            e.cout   = full[W];
            e.ovf    = (x[W-1] == y[W-1]) && (e.result[W-1] != x[W-1]);
        end else begin
            e.result = x - y;
            e.cout   = (x < y);
            e.ovf    = (x[W-1] != y[W-1]) && (e.result[W-1] != x[W-1]);
        end
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; the following edge accepts it, then operands are scrambled.
    task automatic applyStimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sbQueue.push_back(model(o, x, y));
        tick();
        start = 1'b0;
        op    = ~o;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic checkOutput(input string tag, input bit interfere);
        int  cycle = 1;
        bit  seen  = 1'b0;
        int  extraDone = 0;
        expT e;
        checkValue({tag, " busy"}, W'(busy), W'(1));
        while (!seen && cycle < 20) begin
            start = interfere && (cycle == 2 || cycle == 4);
            if (start) begin
                op = $urandom_range(0, 1);
                a  = W'($urandom);
                b  = W'($urandom);
            end
            tick();
            cycle++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checkValue({tag, " doneSeen"}, W'(seen), W'(1));
        if (seen && sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkValue({tag, " latency"}, W'(cycle), W'(NIBBLES + 1));
            checkValue({tag, " result"}, result, e.result);
            checkValue({tag, " cout"}, W'(cout), W'(e.cout));
`ifdef ALU_SEQ_OVF_EN
            checkValue({tag, " ovf"}, W'(ovf), W'(e.ovf));
`endif
            start = interfere;
            tick();
            start = 1'b0;
            checkValue({tag, " donePulse"}, W'(done), W'(0));
            checkValue({tag, " idleBusy"}, W'(busy), W'(0));
            checkValue({tag, " resultHeld"}, result, e.result);
            if (interfere) begin
                for (int i = 0; i < 6; i++) begin
                    tick();
                    if (done || busy) extraDone++;
                end
                checkValue({tag, " noSpuriousDone"}, W'(extraDone), W'(0));
            end
        end else if (sbQueue.size() > 0) begin
            void'(sbQueue.pop_front());
        end
    endtask

    initial begin
        int quietDone = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        checkValue("reset busy", W'(busy), W'(0));
        checkValue("reset done", W'(done), W'(0));
        checkValue("reset result", result, W'(0));
        checkValue("reset cout", W'(cout), W'(0));
`ifdef ALU_SEQ_OVF_EN
        checkValue("reset ovf", W'(ovf), W'(0));
`endif
        rst_n = 1'b1;

        applyStimulus(1'b0, 16'h1234, 16'h0FCD);
        checkOutput("add1234", 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001);
        checkOutput("addWrap", 1'b0);
        applyStimulus(1'b1, 16'h0005, 16'h0007);
        checkOutput("subBorrow", 1'b0);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001);
        checkOutput("addOvf", 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0001);
        checkOutput("subOvf", 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            checkOutput("random", 1'b0);
        end

        applyStimulus(1'b0, 16'hA5A5, 16'h0F0F);
        checkOutput("ignoreStart", 1'b1);

        applyStimulus(1'b0, 16'h4321, 16'h1111);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        void'(sbQueue.pop_back());
        checkValue("abort busy", W'(busy), W'(0));
        checkValue("abort done", W'(done), W'(0));
        checkValue("abort result", result, W'(0));
        checkValue("abort cout", W'(cout), W'(0));
`ifdef ALU_SEQ_OVF_EN
        checkValue("abort ovf", W'(ovf), W'(0));
`endif
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) quietDone++;
        end
        checkValue("abort noDone", W'(quietDone), W'(0));

        applyStimulus(1'b1, 16'h1000, 16'h0001);
        checkOutput("afterAbort", 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  operation request; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = add, 1 = subtract (A - B); sampled with start.
REQ-006 SHALL have port a  input  W  operand A; sampled with start.
REQ-007 SHALL have port b  input  W  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  single-cycle pulse in DONE.
REQ-010 SHALL have port result  output  W  sum or difference; valid from done until the next accepted start.
REQ-011 SHALL have port cout  output  1  final carry XOR op, i.e. carry-out for add, borrow for subtract.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow; present only with ALU_SEQ_OVF_EN.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 SHALL latch a, b, op, clear the slice index to 0, load carry register with op, clear result, and go to RUN.
REQ-015 IDLE with start=0 SHALL stay in IDLE with all outputs held.
REQ-016 Each RUN cycle SHALL compute one slice: {c,s} = A[i] + (B[i] XOR {4{op}}) + carry; write s to result[4i+3:4i]; carry <= c; i <= i+1.
REQ-017 RUN SHALL go to DONE after slice NIBBLES-1 and remain otherwise.
REQ-018 DONE SHALL assert done for exactly one cycle, present cout = carry XOR op, and then return to IDLE.
REQ-019 Latency SHALL be NIBBLES+1 cycles from the accepting edge to the done cycle; throughput one op per NIBBLES+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE, with no effect on latched operands or sequencing.
REQ-021 Operands changing after acceptance SHALL NOT affect the result.
REQ-022 result, cout and ovf SHALL hold their values in IDLE until the next accepted start.
REQ-023 Slice index SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1) and SHALL never exceed NIBBLES-1.

Reset
REQ-024 rst_n low SHALL force IDLE immediately, independent of clk.
REQ-025 rst_n low SHALL force busy=0, done=0, result=0, cout=0, ovf=0, carry=0, index=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ALU_SEQ_OVF_EN defined: port ovf exists, set in DONE to (carry into MSB) XOR (carry out of MSB) of the last slice, and held like result.
REQ-029 Macro ALU_SEQ_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package alu_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), the op encoding constants (OP_ADD=0, OP_SUB=1) and the NIBBLE_W=4 constant.
REQ-031 The slice arithmetic SHALL be one combinational sub-module, nibble_addsub: inputs a[3:0], b[3:0], sub, cin; outputs s[3:0], cout, c3 (carry into bit 3).
REQ-032 alu_seq_ctrl SHALL instantiate nibble_addsub exactly once and time-share it across slices.

Verification (NIBBLES=4)
REQ-033 Bench SHALL drive add 0x1234 + 0x0FCD -> done 5 cycles after the accepting edge, result=0x2201, cout=0, ovf=0.
REQ-034 Bench SHALL drive add 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovf=0.
REQ-035 Bench SHALL drive subtract 0x0005 - 0x0007 -> result=0xFFFE, cout=1 (borrow), ovf=0; add 0x7FFF + 0x0001 -> result=0x8000, ovf=1.
REQ-036 Bench SHALL pulse start with new operands during RUN -> ignored; the original result is returned and a second done appears only after a fresh start in IDLE.
REQ-037 Bench SHALL assert rst_n low mid-RUN -> busy, done, result and cout read 0 at once, no done pulse follows, and the next start completes correctly.
